// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with a per-register scoreboard (busy bits + pending count).
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback to the read ports.

module regfile_sb_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_hit,
  input  logic              set_hit,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data_q,
  output logic              busy_q,
  output logic              busy_d
);
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (reset) begin
      data_d = '0;
      busy_d = 1'b0;
    end else begin
      if (wr_hit) begin
        data_d = wr_data;
        busy_d = 1'b0;
      end
      // a new issue to the same register outranks the writeback clear
      if (set_hit) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    busy_q <= busy_d;
  end
endmodule

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rg_wrt_en,
  input  logic [ADDR_W-1:0] rg_wrt_addr,
  input  logic [DATA_W-1:0] rg_wrt_data,
  input  logic [ADDR_W-1:0] rg_rd_addr1,
  input  logic [ADDR_W-1:0] rg_rd_addr2,
  output logic [DATA_W-1:0] rg_rd_data1,
  output logic [DATA_W-1:0] rg_rd_data2,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             busy_q;
  logic [DEPTH-1:0]             busy_d;
  logic [ADDR_W:0]              pend_cnt_q;
  logic [ADDR_W:0]              pend_cnt_d;

  // r0 is hardwired: no storage, never busy
  assign mem[0]    = '0;
  assign busy_q[0] = 1'b0;
  assign busy_d[0] = 1'b0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_ent
    regfile_sb_entry #(.DATA_W(DATA_W)) u_ent (
      .clk     (clk),
      .reset   (reset),
      .wr_hit  (rg_wrt_en && (rg_wrt_addr == ADDR_W'(i))),
      .set_hit (sb_set_en && (sb_set_addr == ADDR_W'(i))),
      .wr_data (rg_wrt_data),
      .data_q  (mem[i]),
      .busy_q  (busy_q[i]),
      .busy_d  (busy_d[i])
    );
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int k = 0; k < DEPTH; k++)
      pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, busy_d[k]};
  end

  always_ff @(posedge clk) begin
    pend_cnt_q <= pend_cnt_d;
  end

  logic wr_fwd, byp1, byp2;
  assign wr_fwd = BYPASS && rg_wrt_en && !reset && (rg_wrt_addr != '0);
  assign byp1   = wr_fwd && (rg_rd_addr1 == rg_wrt_addr);
  assign byp2   = wr_fwd && (rg_rd_addr2 == rg_wrt_addr);

  assign rg_rd_data1 = byp1 ? rg_wrt_data : mem[rg_rd_addr1];
  assign rg_rd_data2 = byp2 ? rg_wrt_data : mem[rg_rd_addr2];
  assign rd_busy1    = byp1 ? 1'b0 : busy_q[rg_rd_addr1];
  assign rd_busy2    = byp2 ? 1'b0 : busy_q[rg_rd_addr2];
  assign stall       = rd_busy1 | rd_busy2;
  assign pend_cnt    = pend_cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus hand sequences for reset, full scoreboard and mid-op reset.
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, reset;
  logic        rg_wrt_en, sb_set_en;
  logic [4:0]  rg_wrt_addr, rg_rd_addr1, rg_rd_addr2, sb_set_addr;
  logic [31:0] rg_wrt_data, rg_rd_data1, rg_rd_data2;
  logic        rd_busy1, rd_busy2, stall;
  logic [5:0]  pend_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr), .rg_wrt_data(rg_wrt_data),
    .rg_rd_addr1(rg_rd_addr1), .rg_rd_addr2(rg_rd_addr2),
    .rg_rd_data1(rg_rd_data1), .rg_rd_data2(rg_rd_data2),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2), .stall(stall), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst, we, se;
    logic [4:0]  wa, sa, r1, r2;
    logic [31:0] wd;
    logic [31:0] d1, d2;
    bit          b1, b2;
    logic [5:0]  pc;
  } vec_t;

  function automatic vec_t mk(bit rst, bit we, logic [4:0] wa, logic [31:0] wd,
                              bit se, logic [4:0] sa, logic [4:0] r1, logic [4:0] r2,
                              logic [31:0] d1, logic [31:0] d2, bit b1, bit b2, logic [5:0] pc);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.se = se; v.sa = sa;
    v.r1 = r1; v.r2 = r2; v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2; v.pc = pc;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1ns later, i.e. the
  // expectation describes state before the coming rising edge (plus any bypass).
  task automatic run(input vec_t v, input string nm);
    @(negedge clk);
    reset = v.rst; rg_wrt_en = v.we; rg_wrt_addr = v.wa; rg_wrt_data = v.wd;
    sb_set_en = v.se; sb_set_addr = v.sa; rg_rd_addr1 = v.r1; rg_rd_addr2 = v.r2;
    #1;
    cmp({nm, ".d1"},    rg_rd_data1,       v.d1);
    cmp({nm, ".d2"},    rg_rd_data2,       v.d2);
    cmp({nm, ".b1"},    32'(rd_busy1),     32'(v.b1));
    cmp({nm, ".b2"},    32'(rd_busy2),     32'(v.b2));
    cmp({nm, ".stall"}, 32'(stall),        32'(v.b1 | v.b2));
    cmp({nm, ".pc"},    32'(pend_cnt),     32'(v.pc));
  endtask

  vec_t tbl[18];

  initial begin
    //             rst we wa  wd            se sa  r1  r2  d1            d2            b1 b2 pc
    tbl[0]  = mk(1, 0, 0,  0,            0, 0,  5,  31, 0,            0,            0, 0, 0);
    tbl[1]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  1,  2,  0,            0,            0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  0,            0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    tbl[3]  = mk(1, 1, 6,  32'h1111,     1, 6,  5,  6,  32'hDEADBEEF, 0,            0, 0, 0);
    tbl[4]  = mk(0, 0, 0,  0,            0, 0,  5,  6,  0,            0,            0, 0, 0);
    tbl[5]  = mk(0, 1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  0,            0,            0, 0, 0);
    tbl[6]  = mk(0, 0, 0,  0,            0, 0,  0,  0,  0,            0,            0, 0, 0);
    tbl[7]  = mk(0, 0, 0,  0,            1, 3,  3,  4,  0,            0,            0, 0, 0);
    tbl[8]  = mk(0, 0, 0,  0,            0, 0,  3,  0,  0,            0,            1, 0, 1);
    tbl[9]  = mk(0, 1, 3,  32'h12,       0, 0,  4,  0,  0,            0,            0, 0, 1);
    tbl[10] = mk(0, 0, 0,  0,            0, 0,  3,  3,  32'h12,       32'h12,       0, 0, 0);
    tbl[11] = mk(0, 1, 7,  32'h77,       1, 7,  1,  2,  0,            0,            0, 0, 0);
    tbl[12] = mk(0, 0, 0,  0,            0, 0,  7,  7,  32'h77,       32'h77,       1, 1, 1);
    tbl[13] = mk(0, 1, 9,  32'h5,        1, 9,  1,  2,  0,            0,            0, 0, 1);
    tbl[14] = mk(0, 1, 9,  32'hA5A5A5A5, 0, 0,  9,  10, BYP ? 32'hA5A5A5A5 : 32'h5, 0, !BYP, 0, 2);
    tbl[15] = mk(0, 0, 0,  0,            0, 0,  9,  7,  32'hA5A5A5A5, 32'h77,       0, 1, 1);
    tbl[16] = mk(0, 1, 7,  32'h70,       0, 0,  1,  2,  0,            0,            0, 0, 1);
    tbl[17] = mk(0, 0, 0,  0,            0, 0,  7,  9,  32'h70,       32'hA5A5A5A5, 0, 0, 0);

    reset = 1'b1; rg_wrt_en = 1'b0; rg_wrt_addr = '0; rg_wrt_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; rg_rd_addr1 = '0; rg_rd_addr2 = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 18; i++) run(tbl[i], $sformatf("v%0d", i));

    // reset held with writes/sets in flight: bypass suppressed, then all outputs 0
    run(mk(1, 1, 4, 32'hABC, 1, 4, 4, 9, 0, 32'hA5A5A5A5, 0, 0, 0), "rst_enter");
    for (int k = 0; k < 4; k++) begin
      logic [4:0] a, b;
      a = 5'(k * 7 + 3);
      b = 5'(k * 11 + 9);
      run(mk(1, 1, a, 32'hCAFE0000 + 32'(k), 1, b, a, b, 0, 0, 0, 0, 0), $sformatf("rst_hold%0d", k));
    end
    run(mk(0, 0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0, 0), "rst_exit");

    // fill the scoreboard r1..r31
    for (int i = 1; i < 32; i++)
      run(mk(0, 0, 0, 0, 1, 5'(i), 5'(i), 5'(i - 1), 0, 0, 0, i > 1, 6'(i - 1)),
          $sformatf("fill%0d", i));
    run(mk(0, 0, 0, 0, 0, 0, 1, 31, 0, 0, 1, 1, 31), "full");
    run(mk(0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 1, 0, 31), "reset_r1");
    run(mk(0, 0, 0, 0, 0, 0, 1, 16, 0, 0, 1, 1, 31), "full_again");

    // reset lands while a write and a set are in flight; neither survives
    run(mk(1, 1, 16, 32'h99, 1, 2, 16, 2, 0, 0, 1, 1, 31), "midop_rst");
    run(mk(0, 0, 0, 0, 0, 0, 16, 2, 0, 0, 0, 0, 0), "midop_after");

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
